// File: rtl/mod_reduce.sv
// rtl/mod_reduce.sv - sequential restoring shift-subtract modular reduction stage
//
// Purpose: reduces a SIZE-bit product modulo a SIZE/2-bit modulus, one product
// bit per clock, and emits the SIZE/2-bit residue on a valid/ready stream.
//
// Ports:
//   clk            clock, all state changes on the rising edge
//   rst            asynchronous active-high reset
//   input_tdata    SIZE-bit product to reduce
//   input_tvalid   product valid
//   input_tready   block is idle and can accept a product
//   modulus        SIZE/2-bit modulus, sampled only on the input handshake edge
//   output_tdata   SIZE/2-bit residue (registered)
//   output_tvalid  residue valid
//   output_tready  downstream accepts the residue
module mod_reduce #(
  parameter int SIZE = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SIZE-1:0]   input_tdata,
  input  logic              input_tvalid,
  output logic              input_tready,
  input  logic [SIZE/2-1:0] modulus,
  output logic [SIZE/2-1:0] output_tdata,
  output logic              output_tvalid,
  input  logic              output_tready
);

  localparam int HALF = SIZE / 2;
  localparam int CW   = $clog2(SIZE);

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [SIZE-1:0]   r_p;
  logic [HALF-1:0]   r_m;
  logic [HALF:0]     r_r;
  logic [CW-1:0]     r_cnt;
  logic              r_mod_zero;
  logic [HALF-1:0]   r_out;

  logic [HALF:0]     w_t;
  logic              w_ge;
  logic [HALF:0]     w_r_next;
  logic              w_accept;
  logic              w_last;
  logic              w_unused_r_msb;

  // Shift the next product bit into the remainder. Since R < M always holds
  // for a non-zero modulus, only R's low HALF bits are significant here.
  assign w_t      = {r_r[HALF-1:0], r_p[SIZE-1]};
  assign w_ge     = (w_t >= {1'b0, r_m});
  assign w_r_next = w_ge ? (w_t - {1'b0, r_m}) : w_t;

  assign w_accept = (r_state == IDLE) && input_tvalid;
  assign w_last   = (r_state == REDUCE) && (r_cnt == CW'(SIZE - 1));

  // R's top bit can only be set when the modulus is zero, and that result is
  // discarded, so it never feeds back into the next iteration.
  assign w_unused_r_msb = r_r[HALF];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    input_tready  = 1'b0;
    output_tvalid = 1'b0;
    case (r_state)
      IDLE: begin
        input_tready = 1'b1;
        if (input_tvalid) begin
          w_state_next = REDUCE;
        end
      end
      REDUCE: begin
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        output_tvalid = 1'b1;
        if (output_tready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p        <= '0;
      r_m        <= '0;
      r_r        <= '0;
      r_cnt      <= '0;
      r_mod_zero <= 1'b0;
      r_out      <= '0;
    end else begin
      if (w_accept) begin
        r_p        <= input_tdata;
        r_m        <= modulus;
        r_r        <= '0;
        r_cnt      <= '0;
        r_mod_zero <= (modulus == '0);
      end else if (r_state == REDUCE) begin
        r_r   <= w_r_next;
        r_p   <= r_p << 1;
        r_cnt <= r_cnt + CW'(1);
        // The residue register is loaded on the final iteration so it is
        // already stable on the edge where output_tvalid rises.
        if (w_last) begin
          r_out <= r_mod_zero ? '0 : w_r_next[HALF-1:0];
        end
      end
    end
  end

  assign output_tdata = r_out;

endmodule

// File: tb/tb_mod_reduce.sv
// tb/tb_mod_reduce.sv - scoreboard testbench for mod_reduce
module tb_mod_reduce;

  localparam int SIZE = 32;
  localparam int HALF = SIZE / 2;

  logic            clk;
  logic            rst;
  logic [SIZE-1:0] input_tdata;
  logic            input_tvalid;
  logic            input_tready;
  logic [HALF-1:0] modulus;
  logic [HALF-1:0] output_tdata;
  logic            output_tvalid;
  logic            output_tready;

  mod_reduce #(.SIZE(SIZE)) dut (
    .clk          (clk),
    .rst          (rst),
    .input_tdata  (input_tdata),
    .input_tvalid (input_tvalid),
    .input_tready (input_tready),
    .modulus      (modulus),
    .output_tdata (output_tdata),
    .output_tvalid(output_tvalid),
    .output_tready(output_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [HALF-1:0] exp;
    int              acc;
  } sb_item_t;

  sb_item_t sb[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_xfer = 0;
  int last_acc = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [HALF-1:0] ref_mod(input logic [SIZE-1:0] p, input logic [HALF-1:0] m);
    logic [SIZE-1:0] r;
    if (m == '0) return '0;
    r = p % {{HALF{1'b0}}, m};
    return r[HALF-1:0];
  endfunction

  // Output monitor: latency check on the rising edge of valid, data check on transfer.
  always @(negedge clk) begin
    if (!rst) begin
      if (output_tvalid && !prev_valid) begin
        if (sb.size() > 0) check("latency", cyc - sb[0].acc, 32);
        else check("spurious_valid", {31'd0, output_tvalid}, 0);
      end
      if (output_tvalid && output_tready && sb.size() > 0) begin
        check("residue", {16'd0, output_tdata}, {16'd0, sb[0].exp});
        void'(sb.pop_front());
        n_xfer++;
      end
    end
    prev_valid = output_tvalid;
  end

  // Called just after a rising edge; leaves input_tvalid high on return.
  task automatic send(input logic [SIZE-1:0] p, input logic [HALF-1:0] m);
    sb_item_t it;
    input_tdata  = p;
    modulus      = m;
    input_tvalid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (input_tready) begin
        it.exp   = ref_mod(p, m);
        it.acc   = cyc + 1;
        last_acc = it.acc;
        sb.push_back(it);
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    check("accept_timeout", {31'd0, input_tready}, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && sb.size() > 0; k++) @(negedge clk);
    check("drain_timeout", sb.size(), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_tready", {31'd0, input_tready}, 1);
    check("idle_tvalid", {31'd0, output_tvalid}, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int a1;
    int x0;
    rst = 1'b1;
    input_tdata = '0;
    input_tvalid = 1'b0;
    modulus = '0;
    output_tready = 1'b1;
    #1;
    check("rst_tready", {31'd0, input_tready}, 1);
    check("rst_tvalid", {31'd0, output_tvalid}, 0);
    check("rst_tdata", {16'd0, output_tdata}, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Basic reduction
    send(32'd724608, 16'd65521);
    input_tvalid = 1'b0;
    drain();

    // Back-to-back with input_tvalid held high
    send(32'd724608, 16'd1000);
    a1 = last_acc;
    send(32'd724608, 16'd1);
    check("spacing", last_acc - a1, 34);
    input_tvalid = 1'b0;
    drain();

    // Full-width operands
    send(32'hFFFE0001, 16'd65535);
    send(32'hFFFFFFFF, 16'd65535);
    send(32'hFFFFFFFF, 16'd65521);
    send(32'h8000_0001, 16'h8001);
    input_tvalid = 1'b0;
    drain();

    // Zero modulus
    send(32'd724608, 16'd0);
    input_tvalid = 1'b0;
    drain();

    // Backpressure
    output_tready = 1'b0;
    send(32'd724608, 16'd65521);
    input_tvalid = 1'b0;
    for (int k = 0; k < 100 && !output_tvalid; k++) @(negedge clk);
    check("bp_valid_rise", {31'd0, output_tvalid}, 1);
    x0 = n_xfer;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_data", {16'd0, output_tdata}, 32'd3877);
      check("bp_hold_valid", {31'd0, output_tvalid}, 1);
      check("bp_tready_low", {31'd0, input_tready}, 0);
      @(posedge clk); #1;
    end
    output_tready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_one_xfer", n_xfer - x0, 1);
    check("bp_after_valid", {31'd0, output_tvalid}, 0);
    @(posedge clk); #1;

    // Reset mid-REDUCE
    send(32'd724608, 16'd65521);
    input_tvalid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_tvalid", {31'd0, output_tvalid}, 0);
    check("abort_tready", {31'd0, input_tready}, 1);
    check("abort_tdata", {16'd0, output_tdata}, 0);
    sb.delete();
    x0 = n_xfer;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("no_stale_xfer", n_xfer - x0, 0);
    check("no_stale_valid", {31'd0, output_tvalid}, 0);
    send(32'd724608, 16'd65521);
    input_tvalid = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
